// File: rtl/cpu_int_rdy_ctrl.sv
// cpu_int_rdy_ctrl
// Interrupt and bus-ready controller that sits between a small CPU and its peripherals.
//   - Eight level-sensitive IRQ sources, each with an enable bit and a sticky pending bit.
//     Software clears a pending bit by writing 1 to it.
//   - One edge-triggered NMI with an enable bit, a sticky status bit and an acknowledge
//     handshake from the CPU.
//   - A RUN / WAIT_READ / HALTED machine that drives RDY and grants the bus to a DMA engine.
//     The CPU only honours RDY=0 on a read, so the grant waits until a read is seen.
//
// Register map (reg_addr):
//   0 IRQEN  : read/write interrupt enables
//   1 IRQST  : pending bits; write 1 to clear
//   2 NMICTL : bit0 nmi_en (r/w), bit7 NMI status (ro), write 1 to bit6 clears the status
//   3 PRIO   : lowest pending enabled index, or 8'h80 when idle (read-only)
//
// Optional build macro: IRQ_PRIO_EN
//   defined   -> PRIO is backed by a priority encoder
//   undefined -> PRIO reads 8'h00 and no encoder is built
// Writes to address 3 are always ignored.

module cpu_int_rdy_ctrl (
    input  logic       phi2,
    input  logic       rst,
    input  logic [7:0] irq_src,
    input  logic       nmi_src,
    input  logic       nmi_ack,
    input  logic       cpu_rw,
    input  logic       dma_req,
    input  logic       reg_we,
    input  logic [1:0] reg_addr,
    input  logic [7:0] reg_wdata,
    output logic [7:0] reg_rdata,
    output logic       nmi,
    output logic       irq,
    output logic       RDY,
    output logic       dma_gnt
);

    localparam logic [1:0] ADDR_IRQEN  = 2'd0;
    localparam logic [1:0] ADDR_IRQST  = 2'd1;
    localparam logic [1:0] ADDR_NMICTL = 2'd2;
    localparam logic [1:0] ADDR_PRIO   = 2'd3;

    localparam int NMI_EN_BIT   = 0;
    localparam int NMI_CLR_BIT  = 6;

    // ------------------------------------------------------------------
    // Register file state
    // ------------------------------------------------------------------
    logic [7:0] irq_en_reg;
    logic [7:0] irq_en_next;
    logic [7:0] irq_pend_reg;
    logic [7:0] irq_pend_next;
    logic       irq_reg;
    logic       irq_next;

    logic       nmi_en_reg;
    logic       nmi_stat_reg;
    logic       nmi_reg;
    logic [1:0] nmi_hist_reg;   // [0] = newest sample of nmi_src, [1] = the one before

    // Decoded write strobes
    logic       wr_irqen;
    logic       wr_irqst;
    logic       wr_nmictl;

    assign wr_irqen  = reg_we && (reg_addr == ADDR_IRQEN);
    assign wr_irqst  = reg_we && (reg_addr == ADDR_IRQST);
    assign wr_nmictl = reg_we && (reg_addr == ADDR_NMICTL);

    // Enable register takes the written value on the same edge
    assign irq_en_next = wr_irqen ? reg_wdata : irq_en_reg;

    // ------------------------------------------------------------------
    // Per-bit pending logic
    //   set    : source high while currently enabled (wins over W1C)
    //   clear  : software W1C on IRQST
    //   drop   : software writes the enable bit to 0 (dominant)
    // ------------------------------------------------------------------
    logic [7:0] pend_set;
    logic [7:0] pend_clr;
    logic [7:0] pend_drop;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_pend
            assign pend_set[gi]      = irq_src[gi] & irq_en_reg[gi];
            assign pend_clr[gi]      = wr_irqst & reg_wdata[gi];
            assign pend_drop[gi]     = wr_irqen & ~reg_wdata[gi];
            assign irq_pend_next[gi] = ~pend_drop[gi] &
                                       (pend_set[gi] | (irq_pend_reg[gi] & ~pend_clr[gi]));
        end
    endgenerate

    // irq follows the state the pending/enable registers are about to take,
    // so a source pulse shows up on irq at the same edge that latches it.
    assign irq_next = |(irq_pend_next & irq_en_next);

    // Interrupt enable, pending and irq output registers
    always_ff @(posedge phi2) begin
        if (rst) begin
            irq_en_reg   <= 8'h00;
            irq_pend_reg <= 8'h00;
            irq_reg      <= 1'b0;
        end else begin
            irq_en_reg   <= irq_en_next;
            irq_pend_reg <= irq_pend_next;
            irq_reg      <= irq_next;
        end
    end

    // ------------------------------------------------------------------
    // NMI edge detection and handshake
    // A rising edge is two consecutive samples 0 then 1; the request is
    // raised on the edge after the second sample.
    // ------------------------------------------------------------------
    logic nmi_rise;
    logic nmi_fire;

    assign nmi_rise = nmi_hist_reg[0] & ~nmi_hist_reg[1];
    assign nmi_fire = nmi_rise & nmi_en_reg;

    // NMI sample history, enable, sticky status and request output
    always_ff @(posedge phi2) begin
        if (rst) begin
            nmi_hist_reg <= 2'b00;
            nmi_en_reg   <= 1'b0;
            nmi_stat_reg <= 1'b0;
            nmi_reg      <= 1'b0;
        end else begin
            nmi_hist_reg <= {nmi_hist_reg[0], nmi_src};

            if (wr_nmictl) begin
                nmi_en_reg <= reg_wdata[NMI_EN_BIT];
            end

            // A fresh edge beats a software clear of the status bit
            if (nmi_fire) begin
                nmi_stat_reg <= 1'b1;
            end else if (wr_nmictl && reg_wdata[NMI_CLR_BIT]) begin
                nmi_stat_reg <= 1'b0;
            end

            // A fresh edge in the ack cycle keeps the request asserted
            if (nmi_fire) begin
                nmi_reg <= 1'b1;
            end else if (nmi_ack) begin
                nmi_reg <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // RDY / DMA grant state machine
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_WAIT_READ = 2'd1,
        ST_HALTED    = 2'd2
    } bus_state_t;

    bus_state_t state_reg;
    logic       rdy_reg;
    logic       gnt_reg;

    // Bus ownership sequencing with registered RDY / dma_gnt
    always_ff @(posedge phi2) begin
        if (rst) begin
            state_reg <= ST_RUN;
            rdy_reg   <= 1'b1;
            gnt_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (dma_req) begin
                        state_reg <= ST_WAIT_READ;
                        rdy_reg   <= 1'b0;
                        gnt_reg   <= 1'b0;
                    end
                end
                ST_WAIT_READ: begin
                    // The CPU keeps running through writes; only a read cycle
                    // actually stalls it, so the grant waits for cpu_rw=1.
                    if (!dma_req) begin
                        state_reg <= ST_RUN;
                        rdy_reg   <= 1'b1;
                        gnt_reg   <= 1'b0;
                    end else if (cpu_rw) begin
                        state_reg <= ST_HALTED;
                        rdy_reg   <= 1'b0;
                        gnt_reg   <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    if (!dma_req) begin
                        state_reg <= ST_RUN;
                        rdy_reg   <= 1'b1;
                        gnt_reg   <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_RUN;
                    rdy_reg   <= 1'b1;
                    gnt_reg   <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Priority readback
    // ------------------------------------------------------------------
    logic [7:0] prio_value;

`ifdef IRQ_PRIO_EN
    logic [7:0] irq_active;
    assign irq_active = irq_pend_reg & irq_en_reg;

    // Lowest-numbered active source wins; 8'h80 flags "nothing pending"
    always_comb begin
        prio_value = 8'h80;
        for (int i = 7; i >= 0; i--) begin
            if (irq_active[i]) begin
                prio_value = {5'b00000, 3'(i)};
            end
        end
    end
`else
    assign prio_value = 8'h00;
`endif

    // Combinational register readback
    always_comb begin
        reg_rdata = 8'h00;
        case (reg_addr)
            ADDR_IRQEN:  reg_rdata = irq_en_reg;
            ADDR_IRQST:  reg_rdata = irq_pend_reg;
            ADDR_NMICTL: reg_rdata = {nmi_stat_reg, 6'b000000, nmi_en_reg};
            ADDR_PRIO:   reg_rdata = prio_value;
            default:     reg_rdata = 8'h00;
        endcase
    end

    assign irq     = irq_reg;
    assign nmi     = nmi_reg;
    assign RDY     = rdy_reg;
    assign dma_gnt = gnt_reg;

endmodule

// File: tb/tb_cpu_int_rdy_ctrl.sv
// Testbench for cpu_int_rdy_ctrl: directed vector table, hand-written corner
// sequences and a randomized run against a behavioural reference model.
// Honours IRQ_PRIO_EN the same way as the design.

module tb_cpu_int_rdy_ctrl;

    logic       phi2 = 1'b0;
    logic       rst;
    logic [7:0] irq_src;
    logic       nmi_src;
    logic       nmi_ack;
    logic       cpu_rw;
    logic       dma_req;
    logic       reg_we;
    logic [1:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic       nmi;
    logic       irq;
    logic       RDY;
    logic       dma_gnt;

    always #5 phi2 = ~phi2;

    cpu_int_rdy_ctrl dut (
        .phi2      (phi2),
        .rst       (rst),
        .irq_src   (irq_src),
        .nmi_src   (nmi_src),
        .nmi_ack   (nmi_ack),
        .cpu_rw    (cpu_rw),
        .dma_req   (dma_req),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .nmi       (nmi),
        .irq       (irq),
        .RDY       (RDY),
        .dma_gnt   (dma_gnt)
    );

`ifdef IRQ_PRIO_EN
    localparam logic [7:0] PRIO_IDLE = 8'h80;
    localparam logic       PRIO_ON   = 1'b1;
`else
    localparam logic [7:0] PRIO_IDLE = 8'h00;
    localparam logic       PRIO_ON   = 1'b0;
`endif

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: behaviour written directly from the register and
    // bus-handover rules, advanced once per clock edge.
    // ------------------------------------------------------------------
    logic [7:0] m_en;
    logic [7:0] m_pend;
    logic       m_irq;
    logic       m_nmi_en;
    logic       m_stat;
    logic       m_nmi;
    bit         m_hist[$];     // nmi_src samples, newest first
    int         m_bus;         // 0 = CPU owns bus, 1 = waiting for a read, 2 = DMA owns bus

    task automatic model_reset();
        m_en = 8'h00; m_pend = 8'h00; m_irq = 1'b0;
        m_nmi_en = 1'b0; m_stat = 1'b0; m_nmi = 1'b0;
        m_hist = '{1'b0, 1'b0};
        m_bus = 0;
    endtask

    task automatic model_edge();
        bit rising;
        logic [7:0] en_after;
        if (rst) begin
            model_reset();
            return;
        end
        rising = m_hist[0] && !m_hist[1];

        en_after = m_en;
        if (reg_we && reg_addr == 2'd0) en_after = reg_wdata;
        for (int i = 0; i < 8; i++) begin
            if (irq_src[i] && m_en[i])                           m_pend[i] = 1'b1;
            else if (reg_we && reg_addr == 2'd1 && reg_wdata[i]) m_pend[i] = 1'b0;
            if (reg_we && reg_addr == 2'd0 && !reg_wdata[i])     m_pend[i] = 1'b0;
        end
        m_en  = en_after;
        m_irq = |(m_pend & m_en);

        if (rising && m_nmi_en) begin
            m_nmi  = 1'b1;
            m_stat = 1'b1;
        end else begin
            if (nmi_ack) m_nmi = 1'b0;
            if (reg_we && reg_addr == 2'd2 && reg_wdata[6]) m_stat = 1'b0;
        end
        if (reg_we && reg_addr == 2'd2) m_nmi_en = reg_wdata[0];
        m_hist.push_front(nmi_src);
        void'(m_hist.pop_back());

        if (m_bus == 0) begin
            if (dma_req) m_bus = 1;
        end else if (m_bus == 1) begin
            if (!dma_req)    m_bus = 0;
            else if (cpu_rw) m_bus = 2;
        end else begin
            if (!dma_req) m_bus = 0;
        end
    endtask

    function automatic logic [7:0] model_rdata(input logic [1:0] a);
        logic [7:0] p;
        case (a)
            2'd0: return m_en;
            2'd1: return m_pend;
            2'd2: return {m_stat, 6'b000000, m_nmi_en};
            default: begin
                if (!PRIO_ON) return 8'h00;
                p = 8'h80;
                for (int i = 0; i < 8; i++) begin
                    if (m_pend[i] && m_en[i] && p == 8'h80) p = 8'(i);
                end
                return p;
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge phi2);
        model_edge();
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, " irq"},  {7'b0, irq},     {7'b0, m_irq});
        check({tag, " nmi"},  {7'b0, nmi},     {7'b0, m_nmi});
        check({tag, " rdy"},  {7'b0, RDY},     {7'b0, (m_bus != 1 && m_bus != 2)});
        check({tag, " gnt"},  {7'b0, dma_gnt}, {7'b0, (m_bus == 2)});
        check({tag, " rdata"}, reg_rdata,      model_rdata(reg_addr));
        check({tag, " excl"}, {7'b0, RDY & dma_gnt}, 8'h00);
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic       rst;
        logic [7:0] src;
        logic       nsrc, ack, rw, dreq, we;
        logic [1:0] addr;
        logic [7:0] wd;
        logic       e_irq, e_nmi, e_rdy, e_gnt;
        logic [7:0] e_rd;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [7:0] s, input logic ns,
                                input logic ak, input logic rw, input logic dq,
                                input logic we, input logic [1:0] a, input logic [7:0] wd,
                                input logic ei, input logic en, input logic er,
                                input logic eg, input logic [7:0] ed);
        vec_t v;
        v.rst = r; v.src = s; v.nsrc = ns; v.ack = ak; v.rw = rw; v.dreq = dq;
        v.we = we; v.addr = a; v.wd = wd;
        v.e_irq = ei; v.e_nmi = en; v.e_rdy = er; v.e_gnt = eg; v.e_rd = ed;
        return v;
    endfunction

    localparam int NV = 28;
    vec_t tbl[NV];

    initial begin
        //            rst src   ns ak rw dq we a  wd      irq nmi rdy gnt rd
        tbl[0]  = mk(1, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00,  0,  0,  1,  0, 8'h00); // reset
        tbl[1]  = mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h05,  0,  0,  1,  0, 8'h05); // IRQEN=05
        tbl[2]  = mk(0, 8'h04, 0, 0, 0, 0, 0, 1, 8'h00,  1,  0,  1,  0, 8'h04); // pulse src2
        tbl[3]  = mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 8'h00,  1,  0,  1,  0, 8'h04); // sticky
        tbl[4]  = mk(0, 8'h00, 0, 0, 0, 0, 1, 1, 8'h04,  0,  0,  1,  0, 8'h00); // W1C
        tbl[5]  = mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h04,  0,  0,  1,  0, 8'h04); // IRQEN=04
        tbl[6]  = mk(0, 8'h04, 0, 0, 0, 0, 1, 1, 8'h04,  1,  0,  1,  0, 8'h04); // set beats W1C
        tbl[7]  = mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00,  0,  0,  1,  0, 8'h00); // disable clears
        tbl[8]  = mk(0, 8'h00, 0, 0, 0, 0, 1, 2, 8'h01,  0,  0,  1,  0, 8'h01); // nmi_en=1
        tbl[9]  = mk(0, 8'h00, 1, 0, 0, 0, 0, 2, 8'h00,  0,  0,  1,  0, 8'h01); // nmi_src rises
        tbl[10] = mk(0, 8'h00, 1, 0, 0, 0, 0, 2, 8'h00,  0,  1,  1,  0, 8'h81); // 2nd edge: nmi
        tbl[11] = mk(0, 8'h00, 1, 0, 0, 0, 0, 2, 8'h00,  0,  1,  1,  0, 8'h81); // held high
        tbl[12] = mk(0, 8'h00, 1, 1, 0, 0, 0, 2, 8'h00,  0,  0,  1,  0, 8'h81); // ack
        tbl[13] = mk(0, 8'h00, 1, 0, 0, 0, 0, 2, 8'h00,  0,  0,  1,  0, 8'h81); // no retrigger
        tbl[14] = mk(0, 8'h00, 0, 0, 0, 0, 1, 2, 8'h41,  0,  0,  1,  0, 8'h01); // clear status
        tbl[15] = mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00,  0,  0,  0,  0, 8'h00); // dma_req, write
        tbl[16] = mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00,  0,  0,  0,  0, 8'h00);
        tbl[17] = mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00,  0,  0,  0,  0, 8'h00);
        tbl[18] = mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 8'h00,  0,  0,  0,  1, 8'h00); // read -> grant
        tbl[19] = mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00,  0,  0,  1,  0, 8'h00); // release
        tbl[20] = mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00,  0,  0,  0,  0, 8'h00); // request again
        tbl[21] = mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 8'h00,  0,  0,  1,  0, 8'h00); // drop in WAIT
        tbl[22] = mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00,  0,  0,  1,  0, 8'h00);
        tbl[23] = mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 8'hFF,  0,  0,  1,  0, 8'hFF); // IRQEN=FF
        tbl[24] = mk(0, 8'h28, 0, 0, 0, 0, 0, 1, 8'h00,  1,  0,  1,  0, 8'h28); // src 28
        tbl[25] = mk(0, 8'h00, 0, 0, 1, 1, 0, 1, 8'h00,  1,  0,  0,  0, 8'h28); // WAIT_READ
        tbl[26] = mk(0, 8'h00, 0, 0, 1, 1, 0, 1, 8'h00,  1,  0,  0,  1, 8'h28); // HALTED
        tbl[27] = mk(1, 8'h00, 0, 0, 1, 1, 0, 0, 8'h00,  0,  0,  1,  0, 8'h00); // reset mid-DMA
    end

    task automatic drive(input logic r, input logic [7:0] s, input logic ns, input logic ak,
                         input logic rw, input logic dq, input logic we,
                         input logic [1:0] a, input logic [7:0] wd);
        rst = r; irq_src = s; nmi_src = ns; nmi_ack = ak; cpu_rw = rw;
        dma_req = dq; reg_we = we; reg_addr = a; reg_wdata = wd;
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        string tag;
        model_reset();
        drive(1, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00);
        #2;

        // Directed table
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].rst, tbl[i].src, tbl[i].nsrc, tbl[i].ack, tbl[i].rw,
                  tbl[i].dreq, tbl[i].we, tbl[i].addr, tbl[i].wd);
            tick();
            tag = $sformatf("vec%0d", i);
            $display("%s: irq=%0b nmi=%0b rdy=%0b gnt=%0b rdata=%02h",
                     tag, irq, nmi, RDY, dma_gnt, reg_rdata);
            check({tag, " irq"},   {7'b0, irq},     {7'b0, tbl[i].e_irq});
            check({tag, " nmi"},   {7'b0, nmi},     {7'b0, tbl[i].e_nmi});
            check({tag, " rdy"},   {7'b0, RDY},     {7'b0, tbl[i].e_rdy});
            check({tag, " gnt"},   {7'b0, dma_gnt}, {7'b0, tbl[i].e_gnt});
            check({tag, " rdata"}, reg_rdata,       tbl[i].e_rd);
            check_model({tag, " model"});
        end

        // After reset mid-DMA every register reads back cleared
        for (int a = 0; a < 4; a++) begin
            reg_addr = 2'(a);
            #1;
            $display("post-reset read addr%0d: %02h", a, reg_rdata);
            check($sformatf("post-reset addr%0d", a), reg_rdata, (a == 3) ? PRIO_IDLE : 8'h00);
        end

        // Priority readback: IRQEN=FF, sources 3 and 5 -> index 3
        drive(0, 8'h00, 0, 0, 0, 0, 1, 0, 8'hFF);
        tick();
        drive(0, 8'h28, 0, 0, 0, 0, 0, 3, 8'h00);
        tick();
        $display("prio after src=28: %02h", reg_rdata);
        check("prio src28", reg_rdata, PRIO_ON ? 8'h03 : 8'h00);
        check_model("prio src28 model");
        // Writes to PRIO are ignored
        drive(0, 8'h00, 0, 0, 0, 0, 1, 3, 8'h55);
        tick();
        $display("prio after write 55: %02h", reg_rdata);
        check("prio write ignored", reg_rdata, PRIO_ON ? 8'h03 : 8'h00);
        // Clear bit 3 -> bit 5 is now the lowest
        drive(0, 8'h00, 0, 0, 0, 0, 1, 1, 8'h08);
        tick();
        reg_we = 1'b0; reg_addr = 2'd3;
        #1;
        $display("prio after clearing bit3: %02h", reg_rdata);
        check("prio after w1c", reg_rdata, PRIO_ON ? 8'h05 : 8'h00);

        // Randomized run against the reference model
        for (int c = 0; c < 800; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            irq_src   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            if ($urandom_range(0, 5) == 0) nmi_src = ~nmi_src;
            nmi_ack   = ($urandom_range(0, 7) == 0);
            cpu_rw    = 1'($urandom);
            if ($urandom_range(0, 4) == 0) dma_req = ~dma_req;
            reg_we    = ($urandom_range(0, 3) == 0);
            reg_addr  = 2'($urandom);
            reg_wdata = 8'($urandom);
            tick();
            tag = $sformatf("rnd%0d", c);
            $display("%s: rst=%0b we=%0b a=%0d wd=%02h -> irq=%0b nmi=%0b rdy=%0b gnt=%0b rd=%02h",
                     tag, rst, reg_we, reg_addr, reg_wdata, irq, nmi, RDY, dma_gnt, reg_rdata);
            check_model(tag);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_int_rdy_ctrl.md
CPU_INT_RDY_CTRL -- requirements
Module: cpu_int_rdy_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
- phi2  in  1  sole clock; all state updates on posedge phi2
- rst  in  1  synchronous, active-high reset
- irq_src  in  8  level interrupt requests
- nmi_src  in  1  edge-triggered NMI request
- nmi_ack  in  1  one-cycle pulse from CPU: NMI vector fetch taken
- cpu_rw  in  1  CPU bus direction (1 = read)
- dma_req  in  1  DMA engine requests the bus
- reg_we  in  1  register write strobe
- reg_addr  in  2  register select
- reg_wdata  in  8  write data
- reg_rdata  out  8  read data (combinational from reg_addr)
- nmi  out  1  active-high NMI to the CPU FSM
- irq  out  1  active-high IRQ to the CPU FSM
- RDY  out  1  CPU ready (0 = halt on next read)
- dma_gnt  out  1  bus granted to DMA

Function
REQ-002 Register map:
- addr0 IRQEN: read/write.
- addr1 IRQST: reads the pending bits; writing 1 to a bit clears that bit.
- addr2 NMICTL: bit0 = nmi_en (read/write); bit7 = NMI status (read-only); writing 1 to bit6 clears the NMI status.
- addr3 PRIO: see REQ-015.

REQ-003 irq_pend[i] SHALL be set on any cycle where irq_src[i]=1 and IRQEN[i]=1.

REQ-004 When a pending bit is set and W1C-cleared in the same cycle, set SHALL win.

REQ-005 Writing IRQEN[i]=0 SHALL clear irq_pend[i] on the same edge.

REQ-006 irq SHALL equal the registered OR of (irq_pend & IRQEN), with 1-cycle latency from the source.

REQ-007 A 0->1 transition of nmi_src, sampled on consecutive edges, SHALL set nmi_stat and assert nmi on the next edge, but only when nmi_en=1.

REQ-008 nmi SHALL stay high until nmi_ack=1, then deassert on the following edge.
- nmi_stat SHALL stay set until software clears it.
- A new edge arriving in the same cycle as nmi_ack SHALL keep nmi high.

REQ-009 RDY/DMA state machine, states RUN, WAIT_READ, HALTED:
- RUN: RDY=1, dma_gnt=0. On dma_req=1, go to WAIT_READ and drive RDY=0 on the next edge.
- WAIT_READ: RDY=0. When cpu_rw=1 is sampled, go to HALTED and drive dma_gnt=1 on the next edge. While cpu_rw=0, stay in WAIT_READ (the CPU ignores RDY on writes).
- HALTED: RDY=0, dma_gnt=1. When dma_req=0, go to RUN, with RDY=1 and dma_gnt=0 on the next edge.

REQ-010 If dma_req drops while in WAIT_READ, the machine SHALL return to RUN without asserting dma_gnt.

REQ-011 dma_gnt and RDY SHALL never both be 1.

REQ-012 Interrupt logic SHALL operate independently of the RDY state; nmi and irq remain valid while halted.

Reset
REQ-013 While rst=1, on each edge the block SHALL set:
- state to RUN;
- RDY=1, dma_gnt=0, nmi=0, irq=0;
- IRQEN=0, irq_pend=0, nmi_en=0, nmi_stat=0;
- the nmi_src edge-detect history to 0.

REQ-014 Reset applied mid-DMA (WAIT_READ or HALTED) SHALL release the bus in the same edge (dma_gnt=0, RDY=1), regardless of dma_req.

Configuration
REQ-015 Macro IRQ_PRIO_EN:
- Defined: PRIO (addr3) SHALL read {1'b0, 4'b0, idx[2:0]} for the lowest-numbered set bit of (irq_pend & IRQEN), or 8'h80 when none is set.
- Undefined: addr3 SHALL read 8'h00 and no priority encoder SHALL be synthesized.
- In both cases, writes to addr3 SHALL be ignored.

Verification
REQ-016 Irq masking:
- IRQEN=8'h05, pulse irq_src=8'h04 for one cycle -> irq=1 one edge later, IRQST reads 8'h04.
- Then write IRQST=8'h04 -> irq=0 on the next edge.

REQ-017 NMI edge and ack:
- nmi_en=1, nmi_src 0->1 -> nmi=1 two edges after the transition.
- Holding nmi_src high does not re-trigger.
- nmi_ack pulse -> nmi=0 on the next edge; NMICTL reads 8'h81 until bit6 is written.

REQ-018 DMA during writes:
- dma_req=1 while cpu_rw=0 for 3 cycles, then 1 -> RDY=0 after 1 edge; dma_gnt stays 0 until the edge after cpu_rw=1.
- Release: dma_req=0 -> RDY=1, dma_gnt=0 on the next edge.

REQ-019 Set/clear race: irq_src[2]=1 in the same cycle as a W1C write of IRQST=8'h04 (IRQEN=8'h04) -> IRQST still reads 8'h04.

REQ-020 Reset mid-DMA: HALTED with dma_req=1, assert rst for one cycle -> RDY=1, dma_gnt=0, all registers read 8'h00.
- With IRQ_PRIO_EN defined, PRIO reads 8'h80 after this reset.

REQ-021 With IRQ_PRIO_EN defined: IRQEN=8'hFF, irq_src=8'h28 -> PRIO reads 8'h03.
